// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sched_pkg
// Description : Shared types and defaults for the sprite update scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sched_pkg;

    localparam int N_SPRITES_DEF = 4;
    localparam int MAX_SLOTS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    // Bit bit_idx of the one-hot code of id.
    function automatic logic onehot(input int unsigned id, input int unsigned bit_idx);
        return (id == bit_idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin picker; first set bit of pend at or above start,
//               wrapping to index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    pend,
    input  logic [ID_W-1:0] start,
    output logic            any,
    output logic [ID_W-1:0] id
);

    localparam int DW = 2 * N;

    logic [DW-1:0] w_dbl;
    logic [DW-1:0] w_masked;

    // The upper copy of pend supplies the wrapped candidates below start.
    always_comb begin
        w_dbl    = {pend, pend};
        w_masked = '0;
        for (int j = 0; j < DW; j++) begin
            w_masked[j] = w_dbl[j] & (j >= int'(start));
        end
        any = |pend;
        id  = '0;
        for (int j = DW - 1; j >= 0; j--) begin
            if (w_masked[j]) begin
                id = (j >= N) ? ID_W'(j - N) : ID_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sprite_update_scheduler
// Description : Per-frame round-robin arbiter sharing one sprite update engine.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_update_scheduler
    import sched_pkg::*;
#(
    parameter int N_SPRITES = N_SPRITES_DEF,
    parameter int MAX_SLOTS = MAX_SLOTS_DEF,
    parameter int ID_W      = $clog2(N_SPRITES)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    input  logic [N_SPRITES-1:0] req,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [ID_W-1:0]      upd_id,
    input  logic                 upd_done,
    output logic [N_SPRITES-1:0] grant,
    output logic                 frame_busy,
    output logic                 frame_overrun,
    output logic [ID_W:0]        serviced_cnt
);

    localparam int              CNT_W       = ID_W + 1;
    localparam logic [CNT_W-1:0] MAX_SLOTS_C = CNT_W'(MAX_SLOTS);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(N_SPRITES - 1);

    sched_state_t           state_q, state_d;
    logic [N_SPRITES-1:0]   pend_q, pend_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        upd_id_q, upd_id_d;
    logic [ID_W-1:0]        first_id_q, first_id_d;
    logic [CNT_W-1:0]       slots_q, slots_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   overrun_q, overrun_d;

    logic                   w_pick_any;
    logic [ID_W-1:0]        w_pick_id;
    logic                   w_show;

    rr_pick #(
        .N    (N_SPRITES),
        .ID_W (ID_W)
    ) u_rr_pick (
        .pend  (pend_q),
        .start (rr_ptr_q),
        .any   (w_pick_any),
        .id    (w_pick_id)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        rr_ptr_d   = rr_ptr_q;
        upd_id_d   = upd_id_q;
        first_id_d = first_id_q;
        slots_d    = slots_q;
        cnt_d      = cnt_q;
        // A frame pulse outside IDLE is flagged and otherwise dropped.
        overrun_d  = frame_start && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    pend_d  = req;
                    slots_d = '0;
                    cnt_d   = '0;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!w_pick_any || (slots_q == MAX_SLOTS_C)) begin
                    state_d = IDLE;
                    if (slots_q != '0) begin
                        rr_ptr_d = (first_id_q == LAST_ID) ? '0 : first_id_q + 1'b1;
                    end
                end else begin
                    upd_id_d = w_pick_id;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (upd_ready) begin
                    pend_d[upd_id_q] = 1'b0;
                    if (slots_q == '0) begin
                        first_id_d = upd_id_q;
                    end
                    if (slots_q != MAX_SLOTS_C) begin
                        slots_d = slots_q + 1'b1;
                    end
                    cnt_d   = cnt_q + 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (upd_done) begin
                    state_d = ARB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            upd_id_q   <= '0;
            first_id_q <= '0;
            slots_q    <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rr_ptr_q   <= rr_ptr_d;
            upd_id_q   <= upd_id_d;
            first_id_q <= first_id_d;
            slots_q    <= slots_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign w_show        = (state_q == ISSUE) || (state_q == WAIT);
    assign upd_valid     = (state_q == ISSUE);
    assign upd_id        = upd_id_q;
    assign frame_busy    = (state_q != IDLE);
    assign frame_overrun = overrun_q;
    assign serviced_cnt  = cnt_q;

    for (genvar i = 0; i < N_SPRITES; i++) begin : g_grant
        assign grant[i] = w_show & onehot(32'(upd_id_q), i);
    end

endmodule
`default_nettype wire
